div_sqrt_mvp_arbiter: RTL

Shares one div_sqrt_mvp_wrapper instance between NumReq requesters (core/FPU lanes). Round-robin selection of one pending request. Issues a one-cycle start pulse with registered operands to the unit, then tracks the single outstanding operation. Routes result and flags back to the owner with a valid/ready handshake, and handles per-requester flush (kill) including draining stale unit outputs.

---
 rtl/div_sqrt_mvp_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/div_sqrt_mvp_arbiter.sv
// div_sqrt_mvp_arbiter
// Shares one div_sqrt_mvp_wrapper between NumReq requesters. Picks one pending request
// round-robin, issues a one-cycle start pulse with registered operands, tracks the single
// outstanding operation and returns its result to the owner over a valid/ready handshake.
// A flush from the owner kills the unit operation and drains stale unit outputs.
//
// Ports:
//   Clk_CI, Rst_RBI           clock, asynchronous active-low reset
//   Req_*                     per-requester request channel (valid/ready, op, operands, ctl)
//   Flush_SI                  per-requester abort of an owned operation
//   Rsp_*                     per-requester response valid/ready, shared result/flags bus
//   Div_start_SO .. Kill_SO   command side towards the div/sqrt unit
//   Unit_*                    status and result side from the div/sqrt unit
module div_sqrt_mvp_arbiter #(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned DrainCycles = 3,
    // Widths mirror defs_div_sqrt_mvp so the arbiter stays self-contained.
    localparam int unsigned C_OP_FP64  = 64,
    localparam int unsigned C_RM       = 3,
    localparam int unsigned C_PC       = 6,
    localparam int unsigned C_FS       = 2
) (
    input  logic                        Clk_CI,
    input  logic                        Rst_RBI,
    input  logic [NumReq-1:0]           Req_valid_SI,
    output logic [NumReq-1:0]           Req_ready_SO,
    input  logic [NumReq-1:0]           Req_op_SI,
    input  logic [NumReq*C_OP_FP64-1:0] Req_a_DI,
    input  logic [NumReq*C_OP_FP64-1:0] Req_b_DI,
    input  logic [NumReq*C_RM-1:0]      Req_rm_SI,
    input  logic [NumReq*C_PC-1:0]      Req_pc_SI,
    input  logic [NumReq*C_FS-1:0]      Req_fs_SI,
    input  logic [NumReq-1:0]           Flush_SI,
    output logic [NumReq-1:0]           Rsp_valid_SO,
    input  logic [NumReq-1:0]           Rsp_ready_SI,
    output logic [C_OP_FP64-1:0]        Rsp_result_DO,
    output logic [4:0]                  Rsp_fflags_SO,
    output logic                        Div_start_SO,
    output logic                        Sqrt_start_SO,
    output logic [C_OP_FP64-1:0]        Operand_a_DO,
    output logic [C_OP_FP64-1:0]        Operand_b_DO,
    output logic [C_RM-1:0]             RM_SO,
    output logic [C_PC-1:0]             Precision_ctl_SO,
    output logic [C_FS-1:0]             Format_sel_SO,
    output logic                        Kill_SO,
    input  logic                        Unit_ready_SI,
    input  logic                        Unit_done_SI,
    input  logic [C_OP_FP64-1:0]        Unit_result_DI,
    input  logic [4:0]                  Unit_fflags_SI
);

    localparam int unsigned PtrW = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(DrainCycles + 1);

    typedef enum logic [2:0] {StIdle, StIssue, StBusy, StResp, StDrain} state_e;

    state_e                state_d, state_q;
    logic [PtrW-1:0]       ptr_d, ptr_q;
    logic [PtrW-1:0]       owner_d, owner_q;
    logic                  op_d, op_q;
    logic [C_OP_FP64-1:0]  a_d, a_q, b_d, b_q;
    logic [C_RM-1:0]       rm_d, rm_q;
    logic [C_PC-1:0]       pc_d, pc_q;
    logic [C_FS-1:0]       fs_d, fs_q;
    logic [C_OP_FP64-1:0]  result_d, result_q;
    logic [4:0]            fflags_d, fflags_q;
    logic                  kill_d, kill_q;
    logic [CntW-1:0]       cnt_d, cnt_q;

    logic                  gnt_valid;
    logic [PtrW-1:0]       gnt_idx;
    logic                  flush_own;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin : grant_search
        int unsigned idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NumReq) idx = idx - NumReq;
            if (!gnt_valid && Req_valid_SI[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx[PtrW-1:0];
            end
        end
    end

    assign flush_own = Flush_SI[owner_q];

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        rm_d          = rm_q;
        pc_d          = pc_q;
        fs_d          = fs_q;
        result_d      = result_q;
        fflags_d      = fflags_q;
        kill_d        = 1'b0;
        cnt_d         = cnt_q;
        Req_ready_SO  = '0;
        Rsp_valid_SO  = '0;
        Div_start_SO  = 1'b0;
        Sqrt_start_SO = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gnt_valid && Unit_ready_SI) begin
                    Req_ready_SO[gnt_idx] = 1'b1;
                    owner_d = gnt_idx;
                    op_d    = Req_op_SI[gnt_idx];
                    a_d     = Req_a_DI[gnt_idx*C_OP_FP64 +: C_OP_FP64];
                    b_d     = Req_b_DI[gnt_idx*C_OP_FP64 +: C_OP_FP64];
                    rm_d    = Req_rm_SI[gnt_idx*C_RM +: C_RM];
                    pc_d    = Req_pc_SI[gnt_idx*C_PC +: C_PC];
                    fs_d    = Req_fs_SI[gnt_idx*C_FS +: C_FS];
                    ptr_d   = (gnt_idx == PtrW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (flush_own) begin
                    // Start suppressed; kill anyway in case the unit sampled anything.
                    kill_d  = 1'b1;
                    cnt_d   = CntW'(DrainCycles);
                    state_d = StDrain;
                end else begin
                    Div_start_SO  = ~op_q;
                    Sqrt_start_SO = op_q;
                    state_d       = StBusy;
                end
            end
            StBusy: begin
                // Flush wins over a coincident done: that result is discarded.
                if (flush_own) begin
                    kill_d  = 1'b1;
                    cnt_d   = CntW'(DrainCycles);
                    state_d = StDrain;
                end else if (Unit_done_SI) begin
                    result_d = Unit_result_DI;
                    fflags_d = Unit_fflags_SI;
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (flush_own) begin
                    state_d = StIdle;
                end else begin
                    Rsp_valid_SO[owner_q] = 1'b1;
                    if (Rsp_ready_SI[owner_q]) state_d = StIdle;
                end
            end
            StDrain: begin
                // Stale Unit_done_SI from the killed operation is ignored here.
                if (cnt_q <= CntW'(1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            owner_q  <= '0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rm_q     <= '0;
            pc_q     <= '0;
            fs_q     <= '0;
            result_q <= '0;
            fflags_q <= '0;
            kill_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rm_q     <= rm_d;
            pc_q     <= pc_d;
            fs_q     <= fs_d;
            result_q <= result_d;
            fflags_q <= fflags_d;
            kill_q   <= kill_d;
            cnt_q    <= cnt_d;
        end
    end

    assign Operand_a_DO     = a_q;
    assign Operand_b_DO     = b_q;
    assign RM_SO            = rm_q;
    assign Precision_ctl_SO = pc_q;
    assign Format_sel_SO    = fs_q;
    assign Kill_SO          = kill_q;
    assign Rsp_result_DO    = result_q;
    assign Rsp_fflags_SO    = fflags_q;

endmodule
